uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart_transmitter` between NUM_REQ byte producers. It accepts one byte per grant over a valid/ready handshake and pulses the transmitter's `start`. It then tracks `tx_busy`/`tx_done` to completion and reports which requester finished. It sits between the system's message sources and the single UART TX pin driver.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between byte producers
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 active,
    output logic [ID_W-1:0]      cur_id,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [7:0]         tx_data_q;
    logic [ID_W-1:0]    cur_id_q;
    logic               done_q;
    logic               timeout_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic               grant;
    logic [ID_W-1:0]    next_ptr;
    logic               timed_out;
    int                 idx;

    // Find the first valid requester starting at rr_ptr; scanning from the
    // farthest offset down lets the nearest one overwrite the result.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Grant only while the transmitter is idle; pointer wraps at NUM_REQ, not 2^ID_W.
    assign grant     = (state_q == IDLE) && !tx_busy && win_found;
    assign next_ptr  = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
    assign timed_out = (state_q == WAIT_BUSY) && !tx_busy && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (grant) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)        state_d = WAIT_DONE;
                else if (timed_out) state_d = IDLE;
            end
            WAIT_DONE: if (tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        tx_start = (state_q == START);
        active   = (state_q != IDLE);
    end

    // Grant capture, completion/timeout pulses, round-robin pointer and busy-wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            cur_id_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            if (grant) begin
                req_ready_q <= NUM_REQ'(1) << win_id;
                tx_data_q   <= req_data[{win_id, 3'b000} +: 8];
                cur_id_q    <= win_id;
            end
            case (state_q)
                START: cnt_q <= '0;
                WAIT_BUSY: begin
                    if (timed_out) begin
                        timeout_q <= 1'b1;
                        rr_ptr_q  <= next_ptr;
                    end else if (!tx_busy && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        done_q   <= 1'b1;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign cur_id      = cur_id_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int FRAME   = 11;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 active;
    logic [ID_W-1:0]      cur_id;
    logic                 done;
    logic                 timeout_err;

    // Transmitter model: busy rises the cycle after start, lasts FRAME cycles, then done pulses.
    logic model_en = 1'b1;
    logic ext_busy = 1'b0;
    logic model_busy = 1'b0;
    logic model_done = 1'b0;
    int   mcnt = 0;

    assign tx_busy = model_busy | ext_busy;
    assign tx_done = model_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (model_busy) begin
            if (mcnt == 1) begin
                model_busy <= 1'b0;
                model_done <= 1'b1;
            end
            mcnt <= mcnt - 1;
        end else if (tx_start && model_en) begin
            model_busy <= 1'b1;
            mcnt       <= FRAME;
        end
    end

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .active(active), .cur_id(cur_id),
        .done(done), .timeout_err(timeout_err)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   grant_q[$];
    int   data_q[$];
    int   starts, dones, touts;
    logic auto_drop = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        grant_q.delete();
        data_q.delete();
        starts = 0;
        dones  = 0;
        touts  = 0;
    endtask

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_q.push_back(i);
        if (tx_start)    begin starts++; data_q.push_back(int'(tx_data)); end
        if (done)        dones++;
        if (timeout_err) touts++;
        if (auto_drop)   req_valid = req_valid & ~req_ready;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin step(); n++; end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_grants(input int cnt);
        int n;
        n = 0;
        while (grant_q.size() < cnt && n < 400) begin step(); n++; end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"},   32'(req_ready),   32'd0);
        chk({tag, "_start"},   32'(tx_start),    32'd0);
        chk({tag, "_data"},    32'(tx_data),     32'd0);
        chk({tag, "_active"},  32'(active),      32'd0);
        chk({tag, "_cur_id"},  32'(cur_id),      32'd0);
        chk({tag, "_done"},    32'(done),        32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int n;
        clear_log();

        // Reset state
        repeat (3) step();
        chk_idle_outputs("rst");
        rst_n = 1'b1;

        // Single request, byte 0x55 from requester 0
        req_data[7:0] = 8'h55;
        req_valid = 4'b0001;
        auto_drop = 1'b1;
        step();
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_start", 32'(tx_start),  32'd1);
        chk("single_data",  32'(tx_data),   32'h55);
        chk("single_cur",   32'(cur_id),    32'd0);
        chk("single_act",   32'(active),    32'd1);
        step();
        chk("single_start_1cyc", 32'(tx_start),  32'd0);
        chk("single_ready_1cyc", 32'(req_ready), 32'd0);
        wait_done("single_done");
        chk("single_cur_hold", 32'(cur_id),  32'd0);
        chk("single_idle",     32'(active),  32'd0);
        chk("single_data_hold",32'(tx_data), 32'h55);

        // Reset so the four-way round starts from pointer 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < NUM_REQ; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        req_valid = 4'b1111;
        n = 0;
        while (dones < 4 && n < 400) begin step(); n++; end
        chk("all4_dones",  32'(dones),  32'd4);
        chk("all4_starts", 32'(starts), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4_grant%0d", i), 32'(grant_q[i]), 32'(i));
            chk($sformatf("all4_byte%0d", i),  32'(data_q[i]),  32'hA0 + 32'(i));
        end

        // Fairness: requesters 0 and 2 held valid
        clear_log();
        auto_drop = 1'b0;
        req_valid = 4'b0101;
        wait_grants(4);
        req_valid = 4'b0000;
        chk("fair_g0", 32'(grant_q[0]), 32'd0);
        chk("fair_g1", 32'(grant_q[1]), 32'd2);
        chk("fair_g2", 32'(grant_q[2]), 32'd0);
        chk("fair_g3", 32'(grant_q[3]), 32'd2);
        wait_done("fair_done");

        // Timeout: transmitter never goes busy; pointer is now 3, requester 1 wins
        clear_log();
        model_en  = 1'b0;
        auto_drop = 1'b1;
        req_valid = 4'b0010;
        wait_grants(1);
        chk("to_grant", 32'(grant_q[0]), 32'd1);
        n = 0;
        while (!timeout_err && n < 40) begin step(); n++; end
        chk("to_latency", 32'(n),      32'd17);
        chk("to_idle",    32'(active), 32'd0);
        chk("to_nodone",  32'(dones),  32'd0);
        chk("to_count",   32'(touts),  32'd1);
        step();
        chk("to_pulse_1cyc", 32'(timeout_err), 32'd0);
        model_en = 1'b1;
        clear_log();
        req_valid = 4'b1010;
        wait_grants(1);
        req_valid = 4'b0000;
        chk("to_next_grant", 32'(grant_q[0]), 32'd3);
        wait_done("to_next_done");

        // Reset during WAIT_DONE
        clear_log();
        req_valid = 4'b0100;
        wait_grants(1);
        chk("mid_grant", 32'(grant_q[0]), 32'd2);
        n = 0;
        while (!tx_busy && n < 20) begin step(); n++; end
        repeat (3) step();
        chk("mid_active", 32'(active), 32'd1);
        rst_n = 1'b0;
        req_valid = 4'b0001;
        step();
        chk_idle_outputs("mid_rst");
        rst_n = 1'b1;
        n = 0;
        while (tx_busy && n < 40) begin
            chk("mid_no_grant_busy", 32'(req_ready), 32'd0);
            step();
            n++;
        end
        chk("mid_busy_fell", 32'(tx_busy),   32'd0);
        chk("mid_no_grant",  32'(req_ready), 32'd0);
        step();
        chk("mid_resume",    32'(req_ready), 32'h1);
        wait_done("mid_done");

        // Transmitter busy from outside while requester 3 waits
        ext_busy  = 1'b1;
        req_valid = 4'b1000;
        repeat (5) begin
            step();
            chk("blk_no_ready", 32'(req_ready), 32'd0);
        end
        ext_busy = 1'b0;
        step();
        chk("blk_grant", 32'(req_ready), 32'h8);
        chk("blk_cur",   32'(cur_id),    32'd3);
        wait_done("blk_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
